audio_dither: RTL and testbench
===============================

AUDIO_DITHER -- requirements
Module: audio_dither

Interface
REQ-001 Parameter DW, default 16: width of the incoming signed audio sample.
REQ-002 Parameter A, default 8: width of the signed audio word delivered to the FM modulator.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-004 clk  in  1  system clock; the block has exactly one clock.
REQ-005 rst  in  1  reset, synchronous to clk, active-high.
REQ-006 din  in  DW  signed two's-complement audio sample, already synchronous to clk.
REQ-007 din_valid  in  1  one-cycle strobe; din is valid when high.
REQ-008 dith_fact  in  3  dither amplitude select; 0 = off, 7 = full (±1 output LSB TPDF).
REQ-009 dith_disable  in  1  forces dither to 0 when high.
REQ-010 shape_en  in  1  enables first-order error-feedback noise shaping.
REQ-011 dout  out  A  signed quantized audio, held between updates.
REQ-012 dout_valid  out  1  one-cycle strobe marking a new dout.
REQ-013 overrun  out  1  sticky flag: a sample was dropped.

Function
REQ-014 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) shall advance on every clk cycle.
REQ-015 Raw dither d9 shall be the 9-bit signed value lfsr[7:0] minus lfsr[15:8] (range -255..+255).
REQ-016 Applied dither shall be d9 arithmetically shifted right by (7 - dith_fact), and 0 when dith_fact = 0 or dith_disable = 1.
REQ-017 dith_fact, dith_disable, shape_en and the LFSR value shall be sampled in the cycle din_valid is accepted.
REQ-018 Stage 1 (acceptance cycle +1) shall register an 18-bit signed sum: sign-extended din + dither + (shape_en ? err : 0).
REQ-019 Stage 2 (acceptance cycle +2) shall compute q = (sum + 2^(DW-A-1)) >>> (DW-A), i.e. round-half-up.
REQ-020 Stage 2 shall saturate q to the range [-2^(A-1), 2^(A-1)-1].
REQ-021 Stage 2 shall update err to sum - q*2^(DW-A) (range -128..+127 for the defaults) when q is not saturated.
REQ-022 Stage 2 shall clear err to 0 when saturation occurs (anti-windup).
REQ-023 dout shall update and dout_valid shall pulse exactly 2 cycles after an accepted din_valid.
REQ-024 dout shall hold its value otherwise.
REQ-025 The pipeline shall be busy for the 2 cycles following an acceptance.
REQ-026 A din_valid arriving while the pipeline is busy shall be dropped without disturbing the pipeline, and overrun shall be set to 1.
REQ-027 The minimum accepted spacing between din_valid strobes shall be 3 cycles.
REQ-028 overrun shall remain 1 until rst.
REQ-029 When shape_en = 0, err shall still update but shall not be added.
REQ-030 Toggling shape_en mid-stream shall take effect on the next accepted sample.

Reset
REQ-031 While rst = 1 at a clk edge: dout = 0, dout_valid = 0, overrun = 0, err = 0, LFSR = LFSR_SEED, both pipeline stages marked empty.
REQ-032 A sample in flight when rst asserts shall be discarded, with no dout_valid after reset release.
REQ-033 The first din_valid in the first cycle after rst deasserts shall be accepted.

Structure
REQ-034 DW/A defaults, LFSR taps and LFSR_SEED shall live in shared package fm_tx_pkg.
REQ-035 The LFSR shall be a separate sub-module, lfsr16, with ports clk, rst, state[15:0].
REQ-036 The quantizer and error feedback shall remain inside audio_dither.

Verification
REQ-037 Reset then idle -> dout = 0x00, dout_valid = 0, overrun = 0 for all cycles.
REQ-038 dith_disable = 1, shape_en = 0, din = 0x1280 strobe at cycle 0 -> dout_valid at cycle 2, dout = 0x13.
REQ-039 din = 0x7FF0 (no dither) -> dout = 0x7F with err = 0; din = 0x8000 -> dout = 0x80.
REQ-040 shape_en = 1, no dither, din = 0x0040 every 4 cycles -> dout sequence 0, 1, 0, 0 repeating, with a mean of 0.25 LSB.
REQ-041 din_valid at cycles 0 and 1 -> only one dout_valid (cycle 2) and overrun = 1 from cycle 2 until rst.
REQ-042 din = 0, dith_fact = 7, shape_en = 0, 1000 samples -> every dout ∈ {-1, 0, +1}; the same run with dith_fact = 0 -> every dout = 0.

Source files
------------

// File: rtl/fm_tx_pkg.sv
// Shared constants for the FM transmitter audio path: word widths, dither LFSR
// polynomial and seed, plus the single-step LFSR update used by lfsr16.
package fm_tx_pkg;

  localparam int DW_DEF = 16;
  localparam int A_DEF  = 8;

  localparam int DITHER_W = 9;

  typedef logic [15:0] lfsr_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam lfsr_t LFSR_TAPS     = 16'hB400;
  localparam lfsr_t LFSR_SEED_DEF = 16'hACE1;

  function automatic lfsr_t lfsrStep(input lfsr_t s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock and reloads its seed
// on reset so the dither sequence is repeatable.
module lfsr16
  import fm_tx_pkg::*;
#(
  parameter lfsr_t SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  lfsr_t state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= lfsrStep(state_q);
  end

  assign state = state_q;

endmodule

// File: rtl/audio_dither.sv
// Requantizes DW-bit audio to A bits for the FM modulator with optional TPDF
// dither and first-order error-feedback noise shaping, in a two-stage pipeline.
module audio_dither
  import fm_tx_pkg::*;
#(
  parameter int    DW        = DW_DEF,
  parameter int    A         = A_DEF,
  parameter lfsr_t LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  input  logic [2:0]           dith_fact,
  input  logic                 dith_disable,
  input  logic                 shape_en,
  output logic signed [A-1:0]  dout,
  output logic                 dout_valid,
  output logic                 overrun
);

  localparam int SH = DW - A;
  localparam int SW = DW + 2;
  localparam int EW = SH + 1;

  localparam logic signed [SW-1:0] HALF = SW'(2 ** (SH - 1));
  localparam logic signed [SW-1:0] QMAX = SW'(2 ** (A - 1) - 1);
  localparam logic signed [SW-1:0] QMIN = SW'(-(2 ** (A - 1)));

  logic [15:0] lfsrState;

  logic signed [DITHER_W-1:0] ditherRaw;
  logic signed [DITHER_W-1:0] ditherApplied;

  logic                 busy;
  logic                 accept;
  logic                 drop;

  logic signed [SW-1:0] dinExt;
  logic signed [SW-1:0] dithExt;
  logic signed [SW-1:0] errTerm;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sum_q;
  logic                 s1Valid_q;

  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] qFull;
  logic signed [A-1:0]  dout_d;
  logic signed [A-1:0]  dout_q;
  logic                 doutValid_q;
  logic signed [EW-1:0] err_d;
  logic signed [EW-1:0] err_q;
  logic                 overrun_q;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) uLfsr (
    .clk  (clk),
    .rst  (rst),
    .state(lfsrState)
  );

  // Difference of two uniform bytes gives a triangular PDF; the shift scales it down
  always_comb begin
    ditherRaw     = $signed({1'b0, lfsrState[7:0]}) - $signed({1'b0, lfsrState[15:8]});
    ditherApplied = '0;
    if ((dith_fact != 3'd0) && !dith_disable) begin
      ditherApplied = ditherRaw >>> (3'd7 - dith_fact);
    end
  end

  assign busy   = s1Valid_q | doutValid_q;
  assign accept = din_valid & ~busy;
  assign drop   = din_valid & busy;

  always_comb begin
    dinExt  = {{(SW - DW){din[DW-1]}}, din};
    dithExt = {{(SW - DITHER_W){ditherApplied[DITHER_W-1]}}, ditherApplied};
    errTerm = '0;
    if (shape_en) begin
      errTerm = {{(SW - EW){err_q[EW-1]}}, err_q};
    end
    sum_d = dinExt + dithExt + errTerm;
  end

  // Round-half-up, saturate, and clear the feedback error on clipping so it cannot wind up
  always_comb begin
    rounded = sum_q + HALF;
    qFull   = rounded >>> SH;
    dout_d  = qFull[A-1:0];
    err_d   = EW'(sum_q - (qFull <<< SH));
    if (qFull > QMAX) begin
      dout_d = QMAX[A-1:0];
      err_d  = '0;
    end else if (qFull < QMIN) begin
      dout_d = QMIN[A-1:0];
      err_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      s1Valid_q   <= 1'b0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      err_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      s1Valid_q   <= accept;
      doutValid_q <= s1Valid_q;
      overrun_q   <= overrun_q | drop;
      if (accept) begin
        sum_q <= sum_d;
      end
      if (s1Valid_q) begin
        dout_q <= dout_d;
        err_q  <= err_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_dither.sv
// Directed self-checking bench for audio_dither; expected codes are worked out
// by hand from the rounding, saturation, error-feedback and LFSR rules.
module tb_audio_dither;

  logic               clk;
  logic               rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic [2:0]         dith_fact;
  logic               dith_disable;
  logic               shape_en;
  logic signed [7:0]  dout;
  logic               dout_valid;
  logic               overrun;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] expDout;
  logic       expOverrun;
  int         sumOut;
  int         nonZero;
  logic [7:0] shapeSeq [8] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};

  audio_dither dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .dith_fact   (dith_fact),
    .dith_disable(dith_disable),
    .shape_en    (shape_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (3) tick();
    rst        = 1'b0;
    expDout    = 8'h00;
    expOverrun = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [2:0] f,
                               input logic dis, input logic sh);
    din          = d;
    dith_fact    = f;
    dith_disable = dis;
    shape_en     = sh;
    din_valid    = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic expValid,
                             input logic [7:0] expQ, input logic expOvr);
    assertCount++;
    assert (dout_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s dout_valid observed=%0b expected=%0b", tag, dout_valid, expValid);
    end
    assertCount++;
    assert (dout === expQ) else begin
      failCount++;
      $error("[TB] FAIL %s dout observed=%02h expected=%02h", tag, dout, expQ);
    end
    assertCount++;
    assert (overrun === expOvr) else begin
      failCount++;
      $error("[TB] FAIL %s overrun observed=%0b expected=%0b", tag, overrun, expOvr);
    end
  endtask

  // One accepted sample at minimum spacing, checking the exact 2-cycle latency and 1-cycle pulse
  task automatic sendSample(input string tag, input logic [15:0] d, input logic [2:0] f,
                            input logic dis, input logic sh, input logic [7:0] expQ);
    applyStimulus(d, f, dis, sh);
    tick();
    din_valid = 1'b0;
    checkOutput({tag, "_c1"}, 1'b0, expDout, expOverrun);
    tick();
    expDout = expQ;
    checkOutput(tag, 1'b1, expDout, expOverrun);
    tick();
    checkOutput({tag, "_c3"}, 1'b0, expDout, expOverrun);
  endtask

  initial begin
    rst          = 1'b1;
    din          = '0;
    din_valid    = 1'b0;
    dith_fact    = 3'd0;
    dith_disable = 1'b1;
    shape_en     = 1'b0;
    expDout      = 8'h00;
    expOverrun   = 1'b0;

    $display("[TB] reset and idle");
    doReset();
    checkOutput("resetState", 1'b0, 8'h00, 1'b0);
    repeat (10) begin
      tick();
      checkOutput("idle", 1'b0, 8'h00, 1'b0);
    end

    $display("[TB] rounding, saturation and error feedback");
    doReset();
    sendSample("fmt1280",      16'h1280, 3'd0, 1'b1, 1'b0, 8'h13);
    sendSample("shapeOnErr",   16'h00C0, 3'd0, 1'b1, 1'b1, 8'h00);
    sendSample("shapeOff",     16'h00C0, 3'd0, 1'b1, 1'b0, 8'h01);
    sendSample("posSat",       16'h7FF0, 3'd0, 1'b1, 1'b0, 8'h7F);
    sendSample("antiWindup",   16'h0080, 3'd0, 1'b1, 1'b1, 8'h01);
    sendSample("negFull",      16'h8000, 3'd0, 1'b1, 1'b0, 8'h80);
    sendSample("nearMax",      16'h7F7F, 3'd0, 1'b1, 1'b0, 8'h7F);
    sendSample("errKept",      16'h0001, 3'd0, 1'b1, 1'b1, 8'h01);
    sendSample("halfUpNeg",    16'hFF80, 3'd0, 1'b1, 1'b0, 8'h00);
    sendSample("belowHalfNeg", 16'hFF7F, 3'd0, 1'b1, 1'b0, 8'hFF);

    $display("[TB] noise shaping at 4-cycle spacing");
    doReset();
    sumOut = 0;
    for (int i = 0; i < 8; i++) begin
      sendSample("shape40", 16'h0040, 3'd0, 1'b1, 1'b1, shapeSeq[i]);
      sumOut += int'(dout);
      tick();
    end
    assertCount++;
    assert (sumOut == 2) else begin
      failCount++;
      $error("[TB] FAIL shapeMean observed=%0d expected=2", sumOut);
    end

    $display("[TB] back-to-back strobes");
    doReset();
    applyStimulus(16'h1280, 3'd0, 1'b1, 1'b0);
    tick();
    din = 16'h7FF0;
    checkOutput("ovrC1", 1'b0, 8'h00, 1'b0);
    tick();
    din_valid  = 1'b0;
    expDout    = 8'h13;
    expOverrun = 1'b1;
    checkOutput("ovrC2", 1'b1, expDout, expOverrun);
    repeat (4) begin
      tick();
      checkOutput("ovrHold", 1'b0, expDout, expOverrun);
    end
    sendSample("ovrAfter", 16'h0100, 3'd0, 1'b1, 1'b0, 8'h01);
    doReset();
    checkOutput("ovrCleared", 1'b0, 8'h00, 1'b0);

    $display("[TB] strobe in second busy cycle");
    applyStimulus(16'h0100, 3'd0, 1'b1, 1'b0);
    tick();
    din_valid = 1'b0;
    tick();
    din_valid = 1'b1;
    expDout   = 8'h01;
    checkOutput("busyC2", 1'b1, expDout, 1'b0);
    tick();
    din_valid = 1'b0;
    checkOutput("busyC3", 1'b0, expDout, 1'b1);
    tick();
    checkOutput("busyC4", 1'b0, expDout, 1'b1);

    $display("[TB] reset with sample in flight");
    doReset();
    applyStimulus(16'h1280, 3'd0, 1'b1, 1'b0);
    tick();
    din_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("flightDropped", 1'b0, 8'h00, 1'b0);
    end

    $display("[TB] directed dither from seed");
    doReset();
    sendSample("dith7",    16'h0050, 3'd7, 1'b0, 1'b0, 8'h01);
    sendSample("dith6",    16'h0050, 3'd6, 1'b0, 1'b0, 8'h01);
    sendSample("dithNeg",  16'h0000, 3'd7, 1'b0, 1'b0, 8'hFF);
    sendSample("dithOff",  16'h007F, 3'd7, 1'b1, 1'b0, 8'h00);
    sendSample("dithAsr",  16'h0085, 3'd4, 1'b0, 1'b0, 8'h00);

    $display("[TB] 1000 samples full dither");
    doReset();
    nonZero = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'h0000, 3'd7, 1'b0, 1'b0);
      tick();
      din_valid = 1'b0;
      tick();
      assertCount++;
      assert ((dout_valid === 1'b1) &&
              ((dout === 8'hFF) || (dout === 8'h00) || (dout === 8'h01))) else begin
        failCount++;
        $error("[TB] FAIL dithRange observed=%02h/%0b expected=FF..01/1", dout, dout_valid);
      end
      if (dout !== 8'h00) nonZero++;
      tick();
    end
    assertCount++;
    assert (nonZero > 0) else begin
      failCount++;
      $error("[TB] FAIL dithActive observed=%0d expected=nonzero", nonZero);
    end

    $display("[TB] 1000 samples no dither");
    doReset();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'h0000, 3'd0, 1'b0, 1'b0);
      tick();
      din_valid = 1'b0;
      tick();
      assertCount++;
      assert ((dout_valid === 1'b1) && (dout === 8'h00)) else begin
        failCount++;
        $error("[TB] FAIL dithZero observed=%02h/%0b expected=00/1", dout, dout_valid);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
